// File: rtl/data_mem_responder_pkg.sv
// Shared types for the data-memory responder: access sizes, FSM states and
// the alignment rule used when deciding whether an access is legal.
package mem_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10,
        MEM_BAD  = 2'b11
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } resp_state_t;

    // Halves need an even address, words a 4-byte aligned one; bytes never misalign.
    function automatic logic is_misaligned(input mem_size_t sz, input logic [1:0] addr_lo);
        case (sz)
            MEM_HALF: return addr_lo[0];
            MEM_WORD: return addr_lo != 2'b00;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_responder_load_align.sv
// Load alignment: picks the addressed byte/halfword out of a little-endian
// memory word and zero- or sign-extends it to 32 bits.
module mem_load_align
    import mem_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_addr_lo,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[{i_addr_lo, 3'b000} +: 8];
        w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
        o_data = '0;
        case (mem_size_t'(i_size))
            MEM_BYTE: o_data = {{24{~i_unsigned & w_byte[7]}}, w_byte};
            MEM_HALF: o_data = {{16{~i_unsigned & w_half[15]}}, w_half};
            MEM_WORD: o_data = i_word;
            default:  o_data = '0;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: answers level memRead/memWrite requests from the core
// after a fixed latency, against an internal flop-array memory.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [31:0] addr,
    input  logic [31:0] writeData,
    input  logic [1:0]  size,
    input  logic        loadUnsigned,
    output logic        busy,
    output logic        ack,
    output logic [31:0] memload,
    output logic        err,
    output logic [1:0]  o_dbg_state
);

    // Handshake: memRead/memWrite are level requests sampled only while idle;
    // busy is high from the cycle after acceptance through the ack cycle, ack
    // pulses for one cycle, and memload/err stay valid until the next ack.

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    resp_state_t r_state;
    resp_state_t w_next;

    logic [CW-1:0] r_cnt;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    mem_size_t     r_size;
    logic          r_unsigned;
    logic          r_rd;
    logic          r_wr;
    logic [31:0]   r_memload;
    logic          r_err;
    logic [31:0]   r_mem [DEPTH_WORDS];

    logic          w_accept;
    logic          w_commit;
    logic          w_err;
    logic          w_we;
    logic [AW-1:0] w_idx;
    logic [3:0]    w_be;
    logic [31:0]   w_lanes;
    logic [31:0]   w_load;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (memRead || memWrite) w_next = WAIT;
            WAIT:    if (r_cnt == '0) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign w_accept    = (r_state == IDLE) && (memRead || memWrite);
    assign w_commit    = (r_state == WAIT) && (r_cnt == '0);
    assign busy        = (r_state != IDLE);
    assign ack         = (r_state == RESP);
    assign memload     = r_memload;
    assign err         = r_err;
    assign o_dbg_state = r_state;

    assign w_idx = r_addr[AW+1:2];
    assign w_err = (r_size == MEM_BAD) || is_misaligned(r_size, r_addr[1:0]) ||
                   (r_addr >= 32'(DEPTH_WORDS * 4)) || (r_rd && r_wr);
    assign w_we  = w_commit && r_wr && !w_err;

    // Store data is replicated across lanes so the byte enables alone pick the target.
    always_comb begin
        w_be    = 4'b0000;
        w_lanes = r_wdata;
        case (r_size)
            MEM_BYTE: begin
                w_be    = 4'b0001 << r_addr[1:0];
                w_lanes = {4{r_wdata[7:0]}};
            end
            MEM_HALF: begin
                w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
                w_lanes = {2{r_wdata[15:0]}};
            end
            MEM_WORD: w_be = 4'b1111;
            default:  w_be = 4'b0000;
        endcase
    end

    mem_load_align u_align (
        .i_word     (r_mem[w_idx]),
        .i_addr_lo  (r_addr[1:0]),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .o_data     (w_load)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_size     <= MEM_BYTE;
            r_unsigned <= 1'b0;
            r_rd       <= 1'b0;
            r_wr       <= 1'b0;
            r_memload  <= '0;
            r_err      <= 1'b0;
            for (int i = 0; i < DEPTH_WORDS; i++) r_mem[i] <= '0;
        end else begin
            if (w_accept) begin
                r_cnt      <= CW'(LATENCY - 1);
                r_addr     <= addr;
                r_wdata    <= writeData;
                r_size     <= mem_size_t'(size);
                r_unsigned <= loadUnsigned;
                r_rd       <= memRead;
                r_wr       <= memWrite;
            end else if (r_state == WAIT && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end

            if (w_commit) begin
                r_err     <= w_err;
                r_memload <= (w_err || !r_rd) ? 32'd0 : w_load;
            end

            for (int l = 0; l < 4; l++) begin
                if (w_we && w_be[l]) r_mem[w_idx][8*l +: 8] <= w_lanes[8*l +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed sequences plus randomized traffic,
// checked against a byte-array model of the memory.
module tb_data_mem_responder;

  localparam int LATENCY     = 2;
  localparam int DEPTH_WORDS = 256;
  localparam int MEM_BYTES   = DEPTH_WORDS * 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        memRead = 1'b0;
  logic        memWrite = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] writeData = '0;
  logic [1:0]  size = '0;
  logic        loadUnsigned = 1'b0;
  logic        busy;
  logic        ack;
  logic [31:0] memload;
  logic        err;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]  mem_b [MEM_BYTES];
  logic [32:0] exp_q [$];
  logic [31:0] last_load;
  logic        last_err;

  data_mem_responder #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .LATENCY     (LATENCY)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .memRead      (memRead),
    .memWrite     (memWrite),
    .addr         (addr),
    .writeData    (writeData),
    .size         (size),
    .loadUnsigned (loadUnsigned),
    .busy         (busy),
    .ack          (ack),
    .memload      (memload),
    .err          (err),
    .o_dbg_state  (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic void model_clear();
    for (int i = 0; i < MEM_BYTES; i++) mem_b[i] = 8'h00;
  endfunction

  function automatic void model_access(input logic rd, input logic wr, input logic [31:0] a,
                                       input logic [31:0] wd, input logic [1:0] sz,
                                       input logic uns, output logic [31:0] ld, output logic e);
    int nb;
    logic [31:0] v;
    logic [31:0] bytev;
    nb = 1 << sz;
    e = (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0) ||
        (a >= MEM_BYTES) || (rd && wr);
    ld = 32'd0;
    if (e) return;
    if (wr) begin
      for (int i = 0; i < nb; i++) begin
        bytev = (wd >> (8 * i)) & 32'hFF;
        mem_b[a + i] = bytev[7:0];
      end
    end else begin
      v = 32'd0;
      for (int i = 0; i < nb; i++) v = v | (32'(mem_b[a + i]) << (8 * i));
      if (!uns && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
      ld = v;
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic scramble_inputs();
    addr         = $urandom;
    writeData    = $urandom;
    size         = 2'($urandom_range(0, 3));
    loadUnsigned = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    while (!ack && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic check_response(input string tag);
    logic [32:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_memload"}, memload, e[31:0]);
    check({tag, "_err"}, {31'd0, err}, {31'd0, e[32]});
    last_load = memload;
    last_err  = err;
  endtask

  task automatic finish_resp(input string tag);
    check({tag, "_busy_resp"}, {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    check({tag, "_ack_low"}, {31'd0, ack}, 32'd0);
    check({tag, "_busy_idle"}, {31'd0, busy}, 32'd0);
    check({tag, "_hold"}, memload, last_load);
  endtask

  // Caller is #1 after an edge with the DUT idle.
  task automatic run_req(input string tag, input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] wd, input logic [1:0] sz, input logic uns);
    logic [31:0] el;
    logic        ee;
    int          waited;
    model_access(rd, wr, a, wd, sz, uns, el, ee);
    exp_q.push_back({ee, el});
    memRead = rd; memWrite = wr; addr = a; writeData = wd; size = sz; loadUnsigned = uns;
    @(posedge clk); #1;
    memRead = 1'b0; memWrite = 1'b0;
    scramble_inputs();
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    wait_ack(waited);
    check({tag, "_latency"}, 32'(waited), 32'(LATENCY));
    check_response(tag);
    finish_resp(tag);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int r, sz_i, n1, n2;
    logic [31:0] a;
    logic [31:0] el;
    logic        ee;

    model_clear();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_memload", memload, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);

    run_req("sw10", 0, 1, 32'h10, 32'hDEADBEEF, 2'b10, 0);
    run_req("lw10", 1, 0, 32'h10, 32'h0, 2'b10, 0);
    check("lw10_val", last_load, 32'hDEADBEEF);
    run_req("lb13", 1, 0, 32'h13, 32'h0, 2'b00, 0);
    check("lb13_val", last_load, 32'hFFFFFFDE);
    run_req("lbu13", 1, 0, 32'h13, 32'h0, 2'b00, 1);
    check("lbu13_val", last_load, 32'h000000DE);
    run_req("lh12", 1, 0, 32'h12, 32'h0, 2'b01, 0);
    check("lh12_val", last_load, 32'hFFFFDEAD);
    run_req("lhu12", 1, 0, 32'h12, 32'h0, 2'b01, 1);
    check("lhu12_val", last_load, 32'h0000DEAD);
    run_req("lb10", 1, 0, 32'h10, 32'h0, 2'b00, 0);
    check("lb10_val", last_load, 32'hFFFFFFEF);

    run_req("sb11", 0, 1, 32'h11, 32'h12345655, 2'b00, 0);
    run_req("lw_sb", 1, 0, 32'h10, 32'h0, 2'b10, 0);
    check("lw_sb_val", last_load, 32'hDEAD55EF);
    run_req("sh12", 0, 1, 32'h12, 32'h0000AAAA, 2'b01, 0);
    run_req("lw_sh", 1, 0, 32'h10, 32'h0, 2'b10, 0);
    check("lw_sh_val", last_load, 32'hAAAA55EF);

    run_req("e_lw12", 1, 0, 32'h12, 32'h0, 2'b10, 0);
    check("e_lw12_flag", {31'd0, last_err}, 32'd1);
    run_req("e_sh13", 0, 1, 32'h13, 32'hFFFF, 2'b01, 0);
    check("e_sh13_flag", {31'd0, last_err}, 32'd1);
    run_req("e_lw400", 1, 0, 32'h400, 32'h0, 2'b10, 0);
    check("e_lw400_flag", {31'd0, last_err}, 32'd1);
    run_req("e_size3", 1, 0, 32'h10, 32'h0, 2'b11, 0);
    check("e_size3_flag", {31'd0, last_err}, 32'd1);
    run_req("e_both", 1, 1, 32'h10, 32'h0, 2'b10, 0);
    check("e_both_flag", {31'd0, last_err}, 32'd1);
    check("e_both_load", last_load, 32'd0);
    run_req("lw_after_err", 1, 0, 32'h10, 32'h0, 2'b10, 0);
    check("lw_after_err_val", last_load, 32'hAAAA55EF);

    // Request held across ack: the second load starts in the first idle cycle.
    model_access(1, 0, 32'h10, 32'h0, 2'b10, 0, el, ee);
    exp_q.push_back({ee, el});
    exp_q.push_back({ee, el});
    memRead = 1'b1; memWrite = 1'b0; addr = 32'h10; size = 2'b10; loadUnsigned = 1'b0;
    @(posedge clk); #1;
    scramble_inputs();
    wait_ack(n1);
    check("b2b_lat1", 32'(n1), 32'(LATENCY));
    check_response("b2b_first");
    check("b2b_first_val", last_load, 32'hAAAA55EF);
    addr = 32'h10; size = 2'b10; loadUnsigned = 1'b0;
    @(posedge clk); #1;
    check("b2b_idle_ack", {31'd0, ack}, 32'd0);
    @(posedge clk); #1;
    memRead = 1'b0;
    scramble_inputs();
    check("b2b_busy2", {31'd0, busy}, 32'd1);
    wait_ack(n2);
    check("b2b_gap", 32'(n2 + 2), 32'(LATENCY + 2));
    check_response("b2b_second");
    check("b2b_second_val", last_load, 32'hAAAA55EF);
    finish_resp("b2b");

    // Reset in the cycle after acceptance aborts the store.
    memRead = 1'b0; memWrite = 1'b1; addr = 32'h20; writeData = 32'h11111111; size = 2'b10;
    @(posedge clk); #1;
    memWrite = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_ack", {31'd0, ack}, 32'd0);
    check("mid_rst_memload", memload, 32'd0);
    check("mid_rst_err", {31'd0, err}, 32'd0);
    run_req("lw20", 1, 0, 32'h20, 32'h0, 2'b10, 0);
    check("lw20_val", last_load, 32'h00000000);

    // Randomized traffic.
    for (int it = 0; it < 300; it++) begin
      r = $urandom_range(0, 9);
      if (r < 8)       a = 32'($urandom_range(0, MEM_BYTES - 1));
      else if (r == 8) a = 32'($urandom_range(MEM_BYTES, MEM_BYTES + 64));
      else             a = $urandom;
      sz_i = ($urandom_range(0, 15) == 0) ? 3 : $urandom_range(0, 2);
      if ($urandom_range(0, 3) != 0 && sz_i < 3) a = a & ~((32'd1 << sz_i) - 32'd1);
      r = $urandom_range(0, 19);
      if (r < 9)       run_req("rnd_ld", 1, 0, a, $urandom, 2'(sz_i), 1'($urandom_range(0, 1)));
      else if (r < 18) run_req("rnd_st", 0, 1, a, $urandom, 2'(sz_i), 1'($urandom_range(0, 1)));
      else             run_req("rnd_both", 1, 1, a, $urandom, 2'(sz_i), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
